// File: rtl/data_mem_resp_pkg.sv
// Shared constants, FSM encoding and helpers for the data-memory responder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package data_mem_resp_pkg;

  localparam int RegBus         = 32;
  localparam int DataAddrBus    = 32;
  localparam int DataMemNum     = 1024;
  localparam int DataMemNumLog2 = 10;

  localparam logic ChipEnable  = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic Stop        = 1'b1;

  // Responder FSM encoding.
  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  // Word index (byte address bits [31:2]) falls inside a DEPTH-word array.
  function automatic logic idx_in_range(input logic [DataAddrBus-3:0] idx,
                                        input int depth);
    return ({2'b00, idx} < 32'(depth));
  endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// MEM-stage load/store bus between the pipeline and the data-memory responder.
// Latency: n/a (wires only).
// Backpressure: responder holds the pipeline through stallreq_o until ack.
interface data_mem_resp_if;
  import data_mem_resp_pkg::*;

  logic                   mem_ce_i;
  logic                   mem_we_i;
  logic [DataAddrBus-1:0] mem_addr_i;
  logic [3:0]             mem_sel_i;
  logic [RegBus-1:0]      mem_data_i;
  logic [RegBus-1:0]      mem_data_o;
  logic                   mem_ack_o;
  logic                   mem_err_o;
  logic                   stallreq_o;

  // Pipeline side: issues requests, observes completion and stall.
  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  mem_data_o, mem_ack_o, mem_err_o, stallreq_o
  );

  // Memory side: accepts requests, produces completion and stall.
  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    output mem_data_o, mem_ack_o, mem_err_o, stallreq_o
  );
endinterface

// File: rtl/dmem_byte_bank.sv
// One byte lane of the data memory: DEPTH x 8 synchronous array.
// Latency: write and read both take effect on the enabling clock edge.
// Backpressure: none; dout holds its value unless re or clr is asserted.
module dmem_byte_bank #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic          clr,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    din,
  output logic [7:0]    dout
);

  logic [7:0] mem [DEPTH];

  // Array storage is not reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= din;
  end

  // Read port register: cleared for out-of-range responses, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      dout <= 8'h00;
    else if (clr) dout <= 8'h00;
    else if (re)  dout <= mem[idx];
  end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: accepts one MEM-stage access, waits, then completes it.
// Latency: ack WAIT_CYCLES+1 cycles after the request cycle; one access in flight.
// Backpressure: stallreq_o high from the request cycle until the cycle before ack.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int DEPTH       = DataMemNum,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_resp_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_e state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept, enter_resp;

  logic                   lat_we;
  logic [DataAddrBus-3:0] lat_idx;
  logic [3:0]             lat_sel;
  logic [RegBus-1:0]      lat_wdata;

  logic                   acc_we;
  logic [DataAddrBus-3:0] acc_idx;
  logic [3:0]             acc_sel;
  logic [RegBus-1:0]      acc_wdata;
  logic                   acc_in_range;
  logic [3:0]             lane_we;
  logic                   rd_en, rd_clr;
  logic [RegBus-1:0]      rdata;
  logic                   unused_addr_lsb;

  assign unused_addr_lsb = ^bus.mem_addr_i[1:0];

  // State and wait-counter registers; reset drops any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DMEM_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: IDLE accepts, WAIT counts down to 1, RESP always returns to IDLE.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      DMEM_IDLE: begin
        if (bus.mem_ce_i == ChipEnable) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt  = DMEM_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = DMEM_WAIT;
            cnt_nxt   = 4'(WAIT_CYCLES);
          end
        end
      end
      DMEM_WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt  = DMEM_RESP;
          enter_resp = 1'b1;
          cnt_nxt    = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DMEM_RESP: state_nxt = DMEM_IDLE;
      default:   state_nxt = DMEM_IDLE;
    endcase
  end

  // Request latch: captured once on acceptance, later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_sel   <= 4'b0000;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_we    <= (bus.mem_we_i == WriteEnable);
      lat_idx   <= bus.mem_addr_i[DataAddrBus-1:2];
      lat_sel   <= bus.mem_sel_i;
      lat_wdata <= bus.mem_data_i;
    end
  end

  // Access fields: with zero wait states the array is touched on the accept
  // edge itself, before the latch holds anything, so take them from the bus.
  always_comb begin
    acc_we    = lat_we;
    acc_idx   = lat_idx;
    acc_sel   = lat_sel;
    acc_wdata = lat_wdata;
    if (state == DMEM_IDLE) begin
      acc_we    = (bus.mem_we_i == WriteEnable);
      acc_idx   = bus.mem_addr_i[DataAddrBus-1:2];
      acc_sel   = bus.mem_sel_i;
      acc_wdata = bus.mem_data_i;
    end
  end

  assign acc_in_range = idx_in_range(acc_idx, DEPTH);
  assign rd_en        = enter_resp & ~acc_we & acc_in_range;
  assign rd_clr       = enter_resp & ~acc_in_range;

  // Lane k holds bits [8k+7:8k]; sel[3] is the big-endian byte offset 0.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign lane_we[k] = enter_resp & acc_we & acc_sel[k] & acc_in_range;

    dmem_byte_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank (
      .clk  (clk),
      .rst  (rst),
      .we   (lane_we[k]),
      .re   (rd_en),
      .clr  (rd_clr),
      .idx  (acc_idx[AW-1:0]),
      .din  (acc_wdata[8*k +: 8]),
      .dout (rdata[8*k +: 8])
    );
  end

  assign bus.mem_data_o = rdata;
  assign bus.mem_ack_o  = (state == DMEM_RESP);
  assign bus.mem_err_o  = (state == DMEM_RESP) & ~idx_in_range(lat_idx, DEPTH);
  assign bus.stallreq_o = (((state == DMEM_IDLE) & (bus.mem_ce_i == ChipEnable)) |
                           (state == DMEM_WAIT)) ? Stop : ~Stop;

endmodule
